// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and helpers for the four-decade BCD counter with multiplexed display scan.
package bcd_scan_counter_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned VALUE_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0]    BCD_MAX   = 4'd9;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Active-low one-cold anode pattern for a scan slot.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [SLOT_W-1:0] slot);
    return ANODE_OFF & ~(NUM_DIGITS'(1) << slot);
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// One BCD decade: up/down counter with ripple carry/borrow in and out.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               up,
  input  logic               cin,
  output logic               cout,
  output logic [DIGIT_W-1:0] digit
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (cin) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + DIGIT_W'(1);
      end else begin
        digit_d = (digit_q == '0) ? BCD_MAX : digit_q - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Pass the step on when this decade wraps in the current direction.
  assign cout  = cin & (up ? (digit_q == BCD_MAX) : (digit_q == '0));
  assign digit = digit_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-decade up/down BCD counter with a time-multiplexed 7-segment digit scan.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  up,
  input  logic                  clr,
  output logic [VALUE_W-1:0]    value,
  output logic [DIGIT_W-1:0]    hex,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  carry
);

  localparam int unsigned     PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [NUM_DIGITS:0]  chain;
  logic [DIGIT_W-1:0]   digits [NUM_DIGITS];

  logic                 carry_q, carry_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;

  assign chain[0] = step;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .up    (up),
      .cin   (chain[i]),
      .cout  (chain[i+1]),
      .digit (digits[i])
    );
    assign value[i*DIGIT_W +: DIGIT_W] = digits[i];
  end

  // Wrap pulse from the top decade; a clear suppresses it.
  always_comb begin
    carry_d = chain[NUM_DIGITS] & ~clr;
  end

  // Free-running prescaler and slot rotation.
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    slot_d = slot_q;
    if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      pre_q   <= '0;
      slot_q  <= '0;
    end else begin
      carry_q <= carry_d;
      pre_q   <= pre_d;
      slot_q  <= slot_d;
    end
  end

  assign carry = carry_q;
  assign hex   = digits[slot_q];
  assign an    = anode_sel(slot_q);

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomised self-checking bench for bcd_scan_counter against an integer-count reference model.
module tb_bcd_scan_counter;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        step;
  logic        up;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        carry;

  int n_cmp;
  int n_fail;

  // Reference model: decimal count, expected carry, edges since reset release.
  int   cnt;
  logic exp_carry;
  int   edges;

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .up    (up),
    .clr   (clr),
    .value (value),
    .hex   (hex),
    .an    (an),
    .carry (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int exp_slot();
    return (edges / SCAN_DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] a;
    a = 4'b1111;
    a[exp_slot()] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_hex();
    logic [15:0] b;
    b = to_bcd(cnt);
    return b[4*exp_slot() +: 4];
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic tick(input logic s, input logic u, input logic c);
    @(negedge clk);
    step = s; up = u; clr = c;
    @(posedge clk);
    if (c) begin
      cnt = 0;
      exp_carry = 1'b0;
    end else if (s && u) begin
      exp_carry = (cnt == 9999);
      cnt = (cnt + 1) % 10000;
    end else if (s) begin
      exp_carry = (cnt == 0);
      cnt = (cnt + 9999) % 10000;
    end else begin
      exp_carry = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    step = 1'b0; up = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    cnt = 0;
    exp_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (value !== 16'h0000 || an !== 4'b1110 || hex !== 4'h0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got value=%h an=%b hex=%h carry=%b, expected 0000 1110 0 0",
               value, an, hex, carry);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (value !== 16'h0001 || an !== exp_an()) begin
      n_fail++;
      $display("FAIL first_edge: got value=%h an=%b, expected 0001 %b", value, an, exp_an());
    end
    repeat (1233) tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (value !== 16'h1234) begin
      n_fail++;
      $display("FAIL reach_1234: got %h expected 1234", value);
    end
    // Asynchronous reset between edges, checked before any clock arrives.
    #3;
    rst_n = 1'b0;
    cnt = 0;
    exp_carry = 1'b0;
    #1;
    n_cmp++;
    if (value !== 16'h0000 || an !== 4'b1110 || hex !== 4'h0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got value=%h an=%b hex=%h carry=%b, expected 0000 1110 0 0",
               value, an, hex, carry);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up10();
    int carries;
    do_reset();
    carries = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (carry !== 1'b0) carries++;
    end
    n_cmp++;
    if (value !== 16'h0010 || carries != 0) begin
      n_fail++;
      $display("FAIL up10: got value=%h carries=%0d, expected 0010 0", value, carries);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (value !== 16'h9999 || carry !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down: got value=%h carry=%b, expected 9999 1", value, carry);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (value !== 16'h0000 || carry !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up: got value=%h carry=%b, expected 0000 1", value, carry);
    end
    tick(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (value !== 16'h0000 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_one_cycle: got value=%h carry=%b, expected 0000 0", value, carry);
    end
  endtask

  task automatic test_clr();
    do_reset();
    repeat (57) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (value !== 16'h0000 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_57: got value=%h carry=%b, expected 0000 0", value, carry);
    end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (value !== 16'h0000 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_at_9999: got value=%h carry=%b, expected 0000 0", value, carry);
    end
  endtask

  task automatic test_scan();
    int bad;
    do_reset();
    repeat (1234) tick(1'b1, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 4 * 4 * SCAN_DIV; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if (an !== exp_an() || hex !== exp_hex() || value !== 16'h1234) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL scan: got an=%b hex=%h value=%h, expected %b %h 1234",
                   an, hex, value, exp_an(), exp_hex());
      end
    end
  endtask

  task automatic test_slot_advance();
    bit found;
    do_reset();
    repeat (999) tick(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if ((edges + 1) % (4 * SCAN_DIV) == 3 * SCAN_DIV) found = 1'b1;
      else tick(1'b0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL slot_wait: timed out waiting for slot-3 boundary");
    end
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (value !== 16'h1000 || an !== 4'b0111 || hex !== 4'h1) begin
      n_fail++;
      $display("FAIL slot_advance: got value=%h an=%b hex=%h, expected 1000 0111 1",
               value, an, hex);
    end
  endtask

  task automatic test_random();
    int bad;
    logic s, u, c;
    do_reset();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      s = 1'($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 31) == 0);
      tick(s, u, c);
      n_cmp++;
      if (value !== to_bcd(cnt) || carry !== exp_carry || an !== exp_an() || hex !== exp_hex()) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: got value=%h carry=%b an=%b hex=%h, expected %h %b %b %h",
                   i, value, carry, an, hex, to_bcd(cnt), exp_carry, exp_an(), exp_hex());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    step = 1'b0; up = 1'b0; clr = 1'b0;
    cnt = 0;
    exp_carry = 1'b0;
    test_reset();
    test_count_up10();
    test_wrap();
    test_clr();
    test_scan();
    test_slot_advance();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
